// File: rtl/cpu_timing_pkg.sv
// Shared types and default timing constants for the CPU timebase.
// The FSM state encoding and PPU-to-CPU clock ratio defaults live here.
package cpu_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_HALT_WAIT = 2'd2,
        ST_HALTED    = 2'd3
    } state_t;

    localparam int CPU_DIV_DEF       = 3;
    localparam int M2_LOW_PHASES_DEF = 1;

endpackage

// File: rtl/cpu_phase_ctr.sv
// Phase counter inside a CPU cycle, plus the boundary flag on its last phase.
// Latency: phase updates one clk after enable; boundary is combinational from state. Backpressure: none.
module cpu_phase_ctr #(
    parameter int CPU_DIV = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [1:0] phase,
    output logic       boundary
);

    localparam logic [1:0] LAST = 2'(CPU_DIV - 1);

    // Disabled (IDLE) holds phase at 0 so the first running cycle starts at phase 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 2'd0;
        end else if (clr || !en || phase == LAST) begin
            phase <= 2'd0;
        end else begin
            phase <= phase + 2'd1;
        end
    end

    assign boundary = en && (phase == LAST);

endmodule

// File: rtl/cpu_timing.sv
// CPU timebase: phase/M2 generation, halt FSM, CPU/DMA/APU strobes and cycle counter.
// Latency: strobes register the boundary decision (appear one clk after it). Backpressure: none.
module cpu_timing
    import cpu_timing_pkg::*;
#(
    parameter int CPU_DIV       = CPU_DIV_DEF,
    parameter int M2_LOW_PHASES = M2_LOW_PHASES_DEF,
    parameter int CNT_W         = 32
) (
    input  logic             clk_ppu,
    input  logic             rst_ppu_n,
    input  logic             run,
    input  logic             cpu_rw,
    input  logic             halt_req,
    output logic [1:0]       cpu_phase,
    output logic             cpu_ce,
    output logic             dma_ce,
    output logic             m2,
    output logic             put_cycle,
    output logic             apu_ce,
    output logic             halt_ack,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [1:0] M2_LOW = 2'(M2_LOW_PHASES);

    state_t state;
    state_t state_nxt;
    logic   boundary;
    logic   cpu_ce_nxt;
    logic   dma_ce_nxt;

    cpu_phase_ctr #(
        .CPU_DIV (CPU_DIV)
    ) u_phase (
        .clk      (clk_ppu),
        .rst_n    (rst_ppu_n),
        .en       (state != ST_IDLE),
        .clr      (!run),
        .phase    (cpu_phase),
        .boundary (boundary)
    );

    always_ff @(posedge clk_ppu or negedge rst_ppu_n) begin
        if (!rst_ppu_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping run wins over everything and is not deferred to a boundary.
    always_comb begin
        state_nxt = state;
        if (!run) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      state_nxt = ST_RUN;
                ST_RUN: begin
                    if (boundary && halt_req) begin
                        state_nxt = cpu_rw ? ST_HALTED : ST_HALT_WAIT;
                    end
                end
                ST_HALT_WAIT: begin
                    if (boundary) begin
                        if (!halt_req) begin
                            state_nxt = ST_RUN;
                        end else if (cpu_rw) begin
                            state_nxt = ST_HALTED;
                        end
                    end
                end
                ST_HALTED: begin
                    if (boundary && !halt_req) begin
                        state_nxt = ST_RUN;
                    end
                end
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_ce_nxt = boundary && (state == ST_RUN || state == ST_HALT_WAIT)
                     && (state_nxt != ST_HALTED);
        dma_ce_nxt = boundary && (state == ST_HALTED);
        m2         = (state != ST_IDLE) && (cpu_phase >= M2_LOW);
    end

    always_ff @(posedge clk_ppu or negedge rst_ppu_n) begin
        if (!rst_ppu_n) begin
            cpu_ce    <= 1'b0;
            dma_ce    <= 1'b0;
            apu_ce    <= 1'b0;
            halt_ack  <= 1'b0;
            put_cycle <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            cpu_ce   <= cpu_ce_nxt;
            dma_ce   <= dma_ce_nxt;
            apu_ce   <= boundary && put_cycle;
            halt_ack <= (state_nxt == ST_HALTED);
            if (boundary) begin
                put_cycle <= !put_cycle;
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

endmodule
